// File: rtl/gray_decoder_8bit_if.sv
// Word stream into and decoded/checked stream out of gray_decoder_8bit.
// Handshake: i_en qualifies i_gray each cycle; o_vld qualifies o_data/o_step_err; no backpressure.
interface gray_decoder_8bit_if #(
   parameter int DW = 8
);
   logic          i_en;
   logic [DW-1:0] i_gray;
   logic          i_clr;
   logic          o_vld;
   logic [DW-1:0] o_data;
   logic          o_step_err;
   logic          o_lock;
   logic [7:0]    o_err_cnt;

   modport master (
      output i_en, i_gray, i_clr,
      input  o_vld, o_data, o_step_err, o_lock, o_err_cnt
   );

   modport slave (
      input  i_en, i_gray, i_clr,
      output o_vld, o_data, o_step_err, o_lock, o_err_cnt
   );
endinterface

// File: rtl/gray_decoder_8bit.sv
// Two-stage Gray-to-binary decoder with a +1 sequence checker (lock / step error / error count).
// The checker evaluates the word in stage 1 and its results emerge alongside o_vld.
module gray_decoder_8bit #(
   parameter int DW       = 8,
   parameter int LOCK_CNT = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   gray_decoder_8bit_if.slave  bus,
   output logic [1:0]          o_dbg_state
);

   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,
      ST_UNLOCKED = 2'd1,
      ST_LOCKED   = 2'd2
   } state_e;

   localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);

   logic          en1_q;
   logic [DW-1:0] gray1_q;
   logic          vld_q;
   logic [DW-1:0] data_q;
   logic [DW-1:0] bin1;
   logic [DW-1:0] ref_inc;
   logic [7:0]    good_inc;
   logic [7:0]    err_inc;

   state_e        state_q, state_d;
   logic [DW-1:0] ref_q, ref_d;
   logic [7:0]    good_q, good_d;
   logic [7:0]    err_q, err_d;
   logic          step_q, step_d;

   // Running XOR from the MSB down gives each binary bit.
   always_comb begin
      logic acc;
      acc  = 1'b0;
      bin1 = '0;
      for (int k = DW - 1; k >= 0; k--) begin
         acc     = acc ^ gray1_q[k];
         bin1[k] = acc;
      end
   end

   assign ref_inc  = ref_q + DW'(1);
   assign good_inc = good_q + 8'd1;
   assign err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         en1_q   <= 1'b0;
         gray1_q <= '0;
         vld_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         en1_q   <= bus.i_en;
         gray1_q <= bus.i_gray;
         vld_q   <= en1_q;
         if (en1_q) data_q <= bin1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_EMPTY;
         ref_q   <= '0;
         good_q  <= '0;
         err_q   <= '0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         good_q  <= good_d;
         err_q   <= err_d;
         step_q  <= step_d;
      end
   end

   // Clear beats a word under evaluation: that word neither errors nor becomes the reference.
   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      good_d  = good_q;
      err_d   = err_q;
      step_d  = 1'b0;
      if (bus.i_clr) begin
         state_d = ST_EMPTY;
         good_d  = '0;
         err_d   = '0;
      end else if (en1_q) begin
         ref_d = bin1;
         case (state_q)
            ST_EMPTY: begin
               good_d  = '0;
               state_d = ST_UNLOCKED;
            end
            ST_UNLOCKED: begin
               if (bin1 == ref_inc) begin
                  good_d = good_inc;
                  if (good_inc == LOCK_TGT) state_d = ST_LOCKED;
               end else begin
                  step_d = 1'b1;
                  err_d  = err_inc;
                  good_d = '0;
               end
            end
            ST_LOCKED: begin
               if (bin1 != ref_inc) begin
                  step_d  = 1'b1;
                  err_d   = err_inc;
                  good_d  = '0;
                  state_d = ST_UNLOCKED;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   assign bus.o_vld      = vld_q;
   assign bus.o_data     = data_q;
   assign bus.o_step_err = step_q;
   assign bus.o_lock     = (state_q == ST_LOCKED);
   assign bus.o_err_cnt  = err_q;
   assign o_dbg_state    = state_q;

endmodule

// File: doc/gray_decoder_8bit.md
# gray_decoder_8bit

Receive-side companion to the binary-to-Gray counter. It accepts a stream of Gray-coded words qualified by an enable and converts each word back to binary through a fixed two-stage pipeline. It also checks that successive decoded words form a +1 (mod 2^DW) counting sequence, and reports lock status and step errors. It sits directly after the Gray source, or after a clock-domain crossing that carries Gray counts, and feeds downstream logic that needs binary counts plus a sequence-integrity indication.

## Interface
- DW, 8, data width in bits; all arithmetic is mod 2^DW.
- LOCK_CNT, 4, consecutive correct increments required to declare lock; legal range 1..255.
- i_clk  in  1  single clock; all logic on the rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_en  in  1  input word valid, sampled every cycle.
- i_gray  in  DW  Gray-coded input word, meaningful only when i_en=1.
- i_clr  in  1  synchronous clear of checker state and error count.
- o_vld  out  1  o_data valid, one pulse per accepted word.
- o_data  out  DW  decoded binary word.
- o_step_err  out  1  high with o_vld when the word is not the previous word + 1.
- o_lock  out  1  checker locked flag; registered and updated with o_vld.
- o_err_cnt  out  8  count of step errors, saturating at 255.

## Operation
- Stage 1 registers i_en and i_gray. Stage 2 computes binary, b[DW-1]=g[DW-1] and b[k]=b[k+1]^g[k], then registers it to o_data.
- o_vld is a copy of i_en delayed by 2 cycles. There is no backpressure, so every i_en=1 cycle yields exactly one o_vld pulse.
- Gaps in i_en do not disturb the checker. The expected value stays (last word + 1).
- Checker states:
  - EMPTY: no reference word. The next valid word becomes the reference. No error is flagged, good_cnt is set to 0, and the state moves to UNLOCKED.
  - UNLOCKED: if the word equals ref+1, good_cnt increments. When good_cnt reaches LOCK_CNT, the state moves to LOCKED. Otherwise o_step_err=1, o_err_cnt increments, and good_cnt is set to 0.
  - LOCKED: if the word equals ref+1, the state stays LOCKED. Otherwise o_step_err=1, o_err_cnt increments, good_cnt is set to 0, and the state moves to UNLOCKED.
- In every state, each valid word becomes the new ref, including a mismatched word, so the checker resynchronises immediately.
- Wrap-around: ref=2^DW-1 followed by 0 is a correct increment.
- o_lock reflects the state after the current word's evaluation. It asserts in the same cycle as the o_vld of the LOCK_CNT-th consecutive correct word, and drops in the same cycle as the o_vld carrying the o_step_err.
- o_err_cnt saturates at 255 and never wraps.
- i_clr=1:
  - Takes effect at the next edge: state goes to EMPTY, o_err_cnt to 0, good_cnt to 0, and o_lock to 0.
  - The data pipeline is not flushed. Words already in flight still emerge with o_vld, but the checker treats them as starting from EMPTY.
  - If i_clr coincides with a word being evaluated, the clear wins: no error is counted, and that word does not become the reference.

## Timing
- Latency from i_en/i_gray to o_vld/o_data/o_step_err is 2 cycles. Throughput is one word per cycle.
- o_step_err is a 1-cycle pulse, coincident with o_vld.
- Reset values: o_vld=0, o_data=0, o_step_err=0, o_lock=0, o_err_cnt=0; pipeline registers 0; state EMPTY.
- Reset asserted mid-stream:
  - All outputs go to their reset values immediately, asynchronously, and in-flight words are discarded.
  - After release, the first valid word is treated as a new reference.
- When o_vld=0, o_data holds its last value, and o_step_err and o_lock do not change.

## Test plan
- Reset release, then i_en=1 with i_gray = gray(0..255) on consecutive cycles → o_vld for 256 cycles starting 2 cycles later, o_data = 0..255, o_step_err never high, o_lock rises with o_data=4, o_err_cnt=0.
- Continue after 255 (i_gray=0x80) with i_gray=0x00 → o_data=0, no step error, o_lock stays 1; wrap-around is accepted.
- While locked at o_data=10, inject gray(20) next, then gray(21), gray(22), gray(23), gray(24) → o_step_err=1 and o_lock=0 with o_data=20, o_err_cnt=1; o_lock returns to 1 with o_data=24.
- Valid stream with a 3-cycle i_en=0 gap between gray(7) and gray(8) → no o_vld during the gap, no error, o_data resumes at 8.
- Feed 300 non-consecutive words (e.g. gray(0) repeated), then pulse i_clr → o_err_cnt saturates at 255 (first word is reference, 299 errors); after i_clr, o_err_cnt=0, o_lock=0, and the next word raises no error.
- Assert i_rst_n=0 for one cycle mid-stream at data 50, then resume with gray(100), gray(101) → all outputs 0 during reset, first post-reset word 100 raises no error, 101 is accepted.
